decoder_4_16_strobe: RTL and testbench

Registered 4-to-16 one-hot decoder with a valid/ready input handshake and a programmable strobe length. It accepts a 4-bit index and drives the matching bit of a 16-bit one-hot output for a fixed number of cycles, then releases it. It sits on the receiving side of the 16-to-4 encoder path: the encoder compresses one-hot request lines to an index, and this block expands that index back into timed one-hot select/strobe lines.

---
 rtl/decoder_4_16_strobe.sv | 98 +++++++++
 tb/tb_decoder_4_16_strobe.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/decoder_4_16_strobe.sv
// Registered 4-to-16 one-hot decoder with valid/ready input and a HOLD_CYCLES-long strobe.
// Define DEC_BACK_TO_BACK_EN to allow a new code in the final strobe cycle, so y has no zero gap.
module decoder_4_16_strobe #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  i,
  output logic [15:0] y,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned OUT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_c;
  logic               accept_c;

  // State register; reset clears an in-flight strobe without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last_c   = (state_q == HOLD) && (cnt_q == '0);
  assign accept_c = in_valid && in_ready;

  // Next-state: capture the code on acceptance, count down while holding
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          y_d     = OUT_W'(1) << i;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
`ifdef DEC_BACK_TO_BACK_EN
          if (accept_c) begin
            y_d   = OUT_W'(1) << i;
            cnt_d = CNT_W'(HOLD_CYCLES - 1);
          end else begin
            y_d     = '0;
            state_d = IDLE;
          end
`else
          y_d     = '0;
          state_d = IDLE;
`endif
        end
      end
      default: begin
        y_d     = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs; in_ready is gated by rst_n so nothing is taken during reset
  always_comb begin
    in_ready = 1'b0;
    done     = last_c;
    busy     = (state_q == HOLD);
    y        = y_q;
`ifdef DEC_BACK_TO_BACK_EN
    in_ready = rst_n && ((state_q == IDLE) || last_c);
`else
    in_ready = rst_n && (state_q == IDLE);
`endif
  end

endmodule

// File: tb/tb_decoder_4_16_strobe.sv
// Directed self-checking bench for decoder_4_16_strobe with HOLD_CYCLES=3.
module tb_decoder_4_16_strobe;

  localparam int unsigned HC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  i;
  logic [15:0] y;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  decoder_4_16_strobe #(.HOLD_CYCLES(HC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .i        (i),
    .y        (y),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; i = 4'd5;
    step(); step();
    checks++; if (y !== 16'h0000) begin failures++; $display("FAIL reset_y got=%h exp=0000", y); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", in_ready); end
    step(); step();
    checks++; if (y !== 16'h0000) begin failures++; $display("FAIL post_reset_idle_y got=%h exp=0000", y); end
  endtask

  task automatic test_single();
    logic [15:0] ey [1:4];
    logic        ed [1:4];
    ey = '{16'h0400, 16'h0400, 16'h0400, 16'h0000};
    ed = '{1'b0, 1'b0, 1'b1, 1'b0};
    in_valid = 1'b1; i = 4'hA;
    for (int n = 1; n <= 4; n++) begin
      step();
      in_valid = 1'b0;
      checks++; if (y !== ey[n]) begin failures++; $display("FAIL single_y cyc=k+%0d got=%h exp=%h", n, y, ey[n]); end
      checks++; if (done !== ed[n]) begin failures++; $display("FAIL single_done cyc=k+%0d got=%b exp=%b", n, done, ed[n]); end
      checks++; if (busy !== (ey[n] != 16'h0)) begin failures++; $display("FAIL single_busy cyc=k+%0d got=%b", n, busy); end
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_sweep();
    logic [15:0] exp_y;
    exp_y = 16'h0001;
    for (int c = 0; c < 16; c++) begin
      in_valid = 1'b1; i = 4'(c);
      step();
      in_valid = 1'b0;
      checks++; if (y !== exp_y) begin failures++; $display("FAIL sweep_y code=%0d got=%h exp=%h", c, y, exp_y); end
      checks++; if ($countones(y) != 1) begin failures++; $display("FAIL sweep_onehot code=%0d got=%h exp=one_bit", c, y); end
      for (int n = 0; n < int'(HC); n++) step();
      exp_y = exp_y << 1;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ey [1:7];
    logic        ed [1:7];
    int          drop;
`ifdef DEC_BACK_TO_BACK_EN
    ey = '{16'h0008, 16'h0008, 16'h0008, 16'h0020, 16'h0020, 16'h0020, 16'h0000};
    ed = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    drop = 4;
`else
    ey = '{16'h0008, 16'h0008, 16'h0008, 16'h0000, 16'h0020, 16'h0020, 16'h0020};
    ed = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    drop = 5;
`endif
    in_valid = 1'b1; i = 4'd3;
    for (int n = 1; n <= 7; n++) begin
      step();
      i = 4'd5;
      if (n == drop) in_valid = 1'b0;
      checks++; if (y !== ey[n]) begin failures++; $display("FAIL b2b_y cyc=k+%0d got=%h exp=%h", n, y, ey[n]); end
      checks++; if (done !== ed[n]) begin failures++; $display("FAIL b2b_done cyc=k+%0d got=%b exp=%b", n, done, ed[n]); end
      checks++; if (busy !== (ey[n] != 16'h0)) begin failures++; $display("FAIL b2b_busy cyc=k+%0d got=%b", n, busy); end
    end
    for (int n = 0; n < 4; n++) step();
  endtask

  task automatic test_input_stability();
    in_valid = 1'b1; i = 4'd2;
    step();
    in_valid = 1'b0; i = 4'd9;
    for (int n = 1; n <= int'(HC); n++) begin
      checks++; if (y !== 16'h0004) begin failures++; $display("FAIL stable_y cyc=k+%0d got=%h exp=0004", n, y); end
      step();
    end
    checks++; if (y !== 16'h0000) begin failures++; $display("FAIL stable_release got=%h exp=0000", y); end
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1; i = 4'd7;
    step();
    in_valid = 1'b0;
    checks++; if (y !== 16'h0080) begin failures++; $display("FAIL midrst_pre got=%h exp=0080", y); end
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (y !== 16'h0000) begin failures++; $display("FAIL midrst_async_y got=%h exp=0000", y); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
    for (int n = 0; n < 3; n++) begin
      step();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done_hold n=%0d got=%b exp=0", n, done); end
    end
    rst_n = 1'b1;
    in_valid = 1'b1; i = 4'd1;
    for (int n = 1; n <= 4; n++) begin
      step();
      in_valid = 1'b0;
      checks++; if (y !== ((n <= 3) ? 16'h0002 : 16'h0000)) begin failures++; $display("FAIL midrst_new_y cyc=k+%0d got=%h", n, y); end
      checks++; if (done !== (n == 3)) begin failures++; $display("FAIL midrst_new_done cyc=k+%0d got=%b", n, done); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; i = 4'd0;
    test_reset();
    test_single();
    test_sweep();
    test_back_to_back();
    test_input_stability();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
